// File: rtl/hdlc_mon_pkg.sv
// Shared types and constants for the HDLC line monitor.
package hdlc_mon_pkg;

  typedef enum logic {
    HUNT     = 1'b0,
    IN_FRAME = 1'b1
  } hdlcState_t;

  typedef enum logic [1:0] {
    SEL_OK    = 2'd0,
    SEL_ERR   = 2'd1,
    SEL_ABORT = 2'd2,
    SEL_FLAG  = 2'd3
  } rdSel_t;

  localparam logic [7:0]  FLAG_PAT    = 8'h7E;
  localparam logic [7:0]  ABORT_PAT   = 8'h7F;
  localparam int unsigned STUFF_RUN   = 5;
  localparam int unsigned BCNT_W      = 11;
  localparam int unsigned NUM_CLASSES = 4;

endpackage

// File: rtl/hdlc_line_monitor_ch.sv
// One monitored HDLC line: flag/abort/idle detection, frame alignment checks
// and four saturating event counters.
module hdlc_line_monitor_ch
  import hdlc_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IDLE_LEN  = 15,
  parameter int unsigned MAX_BYTES = 128
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Rx,
  input  logic                         RxEn,
  input  logic [NUM_CLASSES-1:0]       ClrSel,
  output logic                         FlagDetect,
  output logic                         AbortDetect,
  output logic                         IdleDetect,
  output logic                         InFrame,
  output logic                         FrameOk,
  output logic                         FrameErr,
  output logic [NUM_CLASSES*CNT_W-1:0] CntFlat
);

  hdlcState_t        state, stateNext;
  logic [7:0]        shiftReg, shiftNext;
  logic [7:0]        onesRun, onesNext;
  logic [BCNT_W-1:0] bitCnt, bitCntNext, bitInc, dataBits;
  logic              stuffed, flagEv, abortEv, okEv, errEv;
  logic [NUM_CLASSES-1:0] ev;
  logic [CNT_W-1:0]  cnt [NUM_CLASSES];

  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    onesNext   = onesRun;
    bitCntNext = bitCnt;
    bitInc     = bitCnt;
    dataBits   = '0;
    stuffed    = 1'b0;
    flagEv     = 1'b0;
    abortEv    = 1'b0;
    okEv       = 1'b0;
    errEv      = 1'b0;
    if (RxEn) begin
      shiftNext = {shiftReg[6:0], Rx};
      stuffed   = !Rx && (onesRun == 8'(STUFF_RUN));
      if (Rx)
        onesNext = (onesRun == 8'(IDLE_LEN)) ? onesRun : onesRun + 8'd1;
      else
        onesNext = '0;
      bitInc     = (stuffed || bitCnt == '1) ? bitCnt : bitCnt + 11'd1;
      dataBits   = bitInc - 11'd8;
      bitCntNext = bitInc;
      if (shiftNext == FLAG_PAT) begin
        flagEv     = 1'b1;
        bitCntNext = '0;
        stateNext  = IN_FRAME;
        // A count of exactly 8 is the closing flag itself: inter-frame fill.
        if (state == IN_FRAME && bitInc != 11'd8) begin
          if (bitInc == '1 || bitInc < 11'd8 || dataBits[2:0] != 3'd0 ||
              32'(dataBits[10:3]) > MAX_BYTES)
            errEv = 1'b1;
          else
            okEv = 1'b1;
        end
      end else if (shiftNext == ABORT_PAT) begin
        abortEv   = 1'b1;
        stateNext = HUNT;
      end
    end
  end

  assign ev = {flagEv, abortEv, errEv, okEv};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= HUNT;
      shiftReg    <= 8'hFF;
      onesRun     <= '0;
      bitCnt      <= '0;
      FlagDetect  <= 1'b0;
      AbortDetect <= 1'b0;
      FrameOk     <= 1'b0;
      FrameErr    <= 1'b0;
      cnt         <= '{default: '0};
    end else begin
      state       <= stateNext;
      shiftReg    <= shiftNext;
      onesRun     <= onesNext;
      bitCnt      <= bitCntNext;
      FlagDetect  <= flagEv;
      AbortDetect <= abortEv;
      FrameOk     <= okEv;
      FrameErr    <= errEv;
      // Clear-on-read reloads with the same-cycle event so none is dropped.
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        if (ClrSel[k])
          cnt[k] <= CNT_W'(ev[k]);
        else if (ev[k] && cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  assign IdleDetect = (onesRun == 8'(IDLE_LEN));
  assign InFrame    = (state == IN_FRAME);

  always_comb begin
    CntFlat = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++)
      CntFlat[k*CNT_W +: CNT_W] = cnt[k];
  end

endmodule

// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC line monitor: NUM_CH independent channel checkers
// sharing one registered statistics read port.
module hdlc_line_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IDLE_LEN  = 15,
  parameter int unsigned MAX_BYTES = 128,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] Rx,
  input  logic [NUM_CH-1:0] RxEn,
  output logic [NUM_CH-1:0] FlagDetect,
  output logic [NUM_CH-1:0] AbortDetect,
  output logic [NUM_CH-1:0] IdleDetect,
  output logic [NUM_CH-1:0] InFrame,
  output logic [NUM_CH-1:0] FrameOk,
  output logic [NUM_CH-1:0] FrameErr,
  input  logic              RdEn,
  input  logic              RdClr,
  input  logic [CH_W-1:0]   RdCh,
  input  logic [1:0]        RdSel,
  output logic [CNT_W-1:0]  RdData,
  output logic              RdValid
);

  logic [NUM_CLASSES*CNT_W-1:0] cntFlat [NUM_CH];
  logic [CNT_W-1:0]             rdMux;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_CLASSES-1:0] clrSel;
    assign clrSel = (RdEn && RdClr && RdCh == CH_W'(c)) ?
                    (NUM_CLASSES'(1) << RdSel) : '0;

    hdlc_line_monitor_ch #(
      .CNT_W     (CNT_W),
      .IDLE_LEN  (IDLE_LEN),
      .MAX_BYTES (MAX_BYTES)
    ) u_ch (
      .Clk         (Clk),
      .Rst         (Rst),
      .Rx          (Rx[c]),
      .RxEn        (RxEn[c]),
      .ClrSel      (clrSel),
      .FlagDetect  (FlagDetect[c]),
      .AbortDetect (AbortDetect[c]),
      .IdleDetect  (IdleDetect[c]),
      .InFrame     (InFrame[c]),
      .FrameOk     (FrameOk[c]),
      .FrameErr    (FrameErr[c]),
      .CntFlat     (cntFlat[c])
    );
  end

  // Out-of-range channel selects read as zero.
  always_comb begin
    rdMux = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (RdCh == CH_W'(c))
        rdMux = cntFlat[c][RdSel*CNT_W +: CNT_W];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      RdValid <= 1'b0;
      RdData  <= '0;
    end else begin
      RdValid <= RdEn;
      if (RdEn)
        RdData <= rdMux;
    end
  end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Directed self-checking bench for hdlc_line_monitor (4 channels).
module tb_hdlc_line_monitor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  Rx, RxEn;
  logic [3:0]  FlagDetect, AbortDetect, IdleDetect, InFrame, FrameOk, FrameErr;
  logic        RdEn, RdClr;
  logic [1:0]  RdCh, RdSel;
  logic [15:0] RdData;
  logic        RdValid;

  int vectors     = 0;
  int miscompares = 0;
  int flagSeen [4];
  int okSeen   [4];
  int errSeen  [4];
  int abortSeen[4];
  int tbOnes   [4];
  logic [15:0] rd;

  hdlc_line_monitor #(
    .NUM_CH    (4),
    .CNT_W     (16),
    .IDLE_LEN  (15),
    .MAX_BYTES (128)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Rx          (Rx),
    .RxEn        (RxEn),
    .FlagDetect  (FlagDetect),
    .AbortDetect (AbortDetect),
    .IdleDetect  (IdleDetect),
    .InFrame     (InFrame),
    .FrameOk     (FrameOk),
    .FrameErr    (FrameErr),
    .RdEn        (RdEn),
    .RdClr       (RdClr),
    .RdCh        (RdCh),
    .RdSel       (RdSel),
    .RdData      (RdData),
    .RdValid     (RdValid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tally(input int ch);
    flagSeen[ch]  += int'(FlagDetect[ch]);
    okSeen[ch]    += int'(FrameOk[ch]);
    errSeen[ch]   += int'(FrameErr[ch]);
    abortSeen[ch] += int'(AbortDetect[ch]);
  endtask

  task automatic clearSeen(input int ch);
    flagSeen[ch] = 0; okSeen[ch] = 0; errSeen[ch] = 0; abortSeen[ch] = 0;
  endtask

  // Drives one strobed bit; returns 1 time unit after the sampling edge.
  task automatic sendBit(input int ch, input logic b);
    Rx[ch]   = b;
    RxEn[ch] = 1'b1;
    @(posedge Clk); #1;
    RxEn[ch] = 1'b0;
    tally(ch);
  endtask

  task automatic sendData(input int ch, input logic b);
    sendBit(ch, b);
    if (b) begin
      tbOnes[ch]++;
      if (tbOnes[ch] == 5) begin
        sendBit(ch, 1'b0);
        tbOnes[ch] = 0;
      end
    end else begin
      tbOnes[ch] = 0;
    end
  endtask

  task automatic sendByte(input int ch, input logic [7:0] v);
    for (int i = 0; i < 8; i++) sendData(ch, v[i]);
  endtask

  task automatic sendFlag(input int ch);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 7; i >= 0; i--) sendBit(ch, f[i]);
    tbOnes[ch] = 0;
  endtask

  task automatic readCnt(input int ch, input int sel, input logic clr, output logic [15:0] d);
    RdEn  = 1'b1;
    RdClr = clr;
    RdCh  = 2'(ch);
    RdSel = 2'(sel);
    @(posedge Clk); #1;
    RdEn  = 1'b0;
    RdClr = 1'b0;
    chk("rd_valid", 32'(RdValid), 32'd1);
    d = RdData;
  endtask

  initial begin
    Rst = 1'b1; Rx = '0; RxEn = '0;
    RdEn = 1'b0; RdClr = 1'b0; RdCh = '0; RdSel = '0;
    for (int c = 0; c < 4; c++) begin clearSeen(c); tbOnes[c] = 0; end
    repeat (3) @(posedge Clk);
    #1;
    // read in flight while reset is held must not produce RdValid
    RdEn = 1'b1;
    @(posedge Clk); #1;
    RdEn = 1'b0;
    chk("rst_rdvalid", 32'(RdValid), 32'd0);
    chk("rst_rddata",  32'(RdData), 32'd0);
    chk("rst_flag",    32'(FlagDetect), 32'd0);
    chk("rst_abort",   32'(AbortDetect), 32'd0);
    chk("rst_idle",    32'(IdleDetect), 32'd0);
    chk("rst_inframe", 32'(InFrame), 32'd0);
    chk("rst_ok",      32'(FrameOk), 32'd0);
    chk("rst_err",     32'(FrameErr), 32'd0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // 20 ones on ch0: idle from the 15th, no abort
    for (int i = 1; i <= 20; i++) begin
      sendBit(0, 1'b1);
      chk($sformatf("idle0_bit%0d", i), 32'(IdleDetect[0]), (i >= 15) ? 32'd1 : 32'd0);
    end
    chk("idle0_abort", 32'(abortSeen[0]), 32'd0);
    chk("idle0_ok",    32'(okSeen[0]), 32'd0);
    chk("idle0_err",   32'(errSeen[0]), 32'd0);

    // ch1: flag, FF 00, FCS 5A C3, flag
    sendFlag(1);
    chk("ch1_inframe", 32'(InFrame[1]), 32'd1);
    sendByte(1, 8'hFF);
    sendByte(1, 8'h00);
    sendByte(1, 8'h5A);
    sendByte(1, 8'hC3);
    chk("ch1_ok_before", 32'(okSeen[1]), 32'd0);
    sendFlag(1);
    chk("ch1_ok_pulse", 32'(FrameOk[1]), 32'd1);
    chk("ch1_flags",    32'(flagSeen[1]), 32'd2);
    chk("ch1_oks",      32'(okSeen[1]), 32'd1);
    readCnt(1, 0, 1'b0, rd);
    chk("ch1_okcnt", 32'(rd), 32'd1);

    // ch2: flag, 13 data bits, flag -> misaligned
    sendFlag(2);
    for (int i = 0; i < 13; i++) sendData(2, 1'(i & 1));
    sendFlag(2);
    chk("ch2_err_pulse", 32'(FrameErr[2]), 32'd1);
    chk("ch2_oks",       32'(okSeen[2]), 32'd0);
    readCnt(2, 1, 1'b0, rd);
    chk("ch2_errcnt", 32'(rd), 32'd1);

    // ch3: flag, 3 bytes, then 0 + 7 ones -> abort
    sendFlag(3);
    for (int i = 0; i < 3; i++) sendByte(3, 8'h55);
    sendBit(3, 1'b0);
    for (int i = 0; i < 6; i++) sendBit(3, 1'b1);
    chk("ch3_inframe_pre", 32'(InFrame[3]), 32'd1);
    chk("ch3_abort_pre",   32'(abortSeen[3]), 32'd0);
    sendBit(3, 1'b1);
    chk("ch3_abort_pulse", 32'(AbortDetect[3]), 32'd1);
    chk("ch3_inframe",     32'(InFrame[3]), 32'd0);
    chk("ch3_okerr",       32'(okSeen[3] + errSeen[3]), 32'd0);
    readCnt(3, 2, 1'b0, rd);
    chk("ch3_abortcnt", 32'(rd), 32'd1);

    // ch0: 129-byte frame (oversize), then 128-byte frame
    clearSeen(0);
    sendFlag(0);
    for (int i = 0; i < 129; i++) sendByte(0, 8'h81);
    sendFlag(0);
    chk("ch0_129_err", 32'(FrameErr[0]), 32'd1);
    chk("ch0_129_ok",  32'(FrameOk[0]), 32'd0);
    for (int i = 0; i < 128; i++) sendByte(0, 8'h81);
    sendFlag(0);
    chk("ch0_128_ok",  32'(FrameOk[0]), 32'd1);
    chk("ch0_128_err", 32'(FrameErr[0]), 32'd0);
    chk("ch0_inframe", 32'(InFrame[0]), 32'd1);
    readCnt(0, 0, 1'b0, rd);
    chk("ch0_okcnt", 32'(rd), 32'd1);
    readCnt(0, 1, 1'b0, rd);
    chk("ch0_errcnt", 32'(rd), 32'd1);

    // ch1: bring FrameOk count to 4
    for (int f = 0; f < 3; f++) begin
      sendByte(1, 8'h3C);
      sendByte(1, 8'hF0);
      sendFlag(1);
    end
    readCnt(1, 0, 1'b0, rd);
    chk("ch1_okcnt4", 32'(rd), 32'd4);

    // fifth frame closes on the same edge as a clear-on-read
    sendByte(1, 8'h3C);
    sendByte(1, 8'hF0);
    for (int i = 0; i < 7; i++) sendBit(1, (i == 0) ? 1'b0 : 1'b1);
    Rx[1] = 1'b0; RxEn[1] = 1'b1;
    RdEn = 1'b1; RdClr = 1'b1; RdCh = 2'd1; RdSel = 2'd0;
    @(posedge Clk); #1;
    RxEn[1] = 1'b0; RdEn = 1'b0; RdClr = 1'b0;
    tally(1);
    tbOnes[1] = 0;
    chk("clr_ok_pulse", 32'(FrameOk[1]), 32'd1);
    chk("clr_rdvalid",  32'(RdValid), 32'd1);
    chk("clr_rddata",   32'(RdData), 32'd4);
    readCnt(1, 0, 1'b0, rd);
    chk("clr_after", 32'(rd), 32'd1);
    readCnt(1, 3, 1'b0, rd);
    chk("ch1_flagcnt", 32'(rd), 32'd6);
    @(posedge Clk); #1;
    chk("rdvalid_drop", 32'(RdValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hdlc_line_monitor.md
# hdlc_line_monitor

Synthesizable, multi-channel HDLC line monitor: a parametrised successor to the testbench-only HDLC protocol checks. It runs the same flag, abort, idle, zero-stuffing and frame-alignment checks in hardware on NUM_CH independent serial receive lines. It emits per-channel event pulses and keeps saturating per-channel statistics counters, read through a shared register-style port. It sits beside the HDLC Rx path, tapping the serial input and bit strobe, and never alters the data stream.

## Interface
- NUM_CH, 4, number of monitored serial channels (1..16)
- CNT_W, 16, statistics counter width
- IDLE_LEN, 15, consecutive ones that constitute idle (8..255)
- MAX_BYTES, 128, largest legal de-stuffed frame length in bytes (including FCS)

- Clk  in  1  clock
- Rst  in  1  synchronous, active-high reset
- Rx  in  NUM_CH  serial line per channel
- RxEn  in  NUM_CH  bit strobe; Rx[c] is sampled when RxEn[c]=1
- FlagDetect  out  NUM_CH  1-cycle pulse: flag 0111_1110 completed
- AbortDetect  out  NUM_CH  1-cycle pulse: abort (0 then 7 ones) completed
- IdleDetect  out  NUM_CH  level: current ones-run ≥ IDLE_LEN
- InFrame  out  NUM_CH  level: channel FSM in IN_FRAME
- FrameOk  out  NUM_CH  1-cycle pulse: legal frame closed
- FrameErr  out  NUM_CH  1-cycle pulse: misaligned or oversize frame closed
- RdEn  in  1  counter read strobe
- RdClr  in  1  clear-on-read qualifier (valid with RdEn)
- RdCh  in  $clog2(NUM_CH)  channel select (min width 1)
- RdSel  in  2  0=FrameOk, 1=FrameErr, 2=Abort, 3=Flag count
- RdData  out  CNT_W  registered read data
- RdValid  out  1  pulse, cycle after RdEn

## Operation
- Per channel: 8-bit shift register of sampled bits, ones-run counter, de-stuffed bit counter (11 bits, saturating), FSM {HUNT, IN_FRAME}.
- Zero-stuffing: a 0 sampled when the ones-run equals exactly 5 is a stuffed bit and is not counted.
- Flag: shift register == 8'h7E after a sample.
  - HUNT: go to IN_FRAME and clear the bit counter.
  - IN_FRAME with bit count 8 (back-to-back flags, no data): inter-frame fill, no frame event, clear the counter.
  - IN_FRAME otherwise: data bits = count − 8.
    - If data bits mod 8 ≠ 0, or data bits/8 > MAX_BYTES: FrameErr.
    - Otherwise: FrameOk.
    - Clear the counter and stay in IN_FRAME; the closing flag also opens the next frame.
- Abort: shift register == 8'h7F after a sample. Fires once per run of ones. IN_FRAME goes to HUNT; no FrameOk or FrameErr.
- Idle: the ones-run counter saturates at IDLE_LEN. IdleDetect is high while it equals IDLE_LEN and clears on the next sampled 0.
- Counters: one per channel per RdSel class, saturating at 2^CNT_W−1; each increments on its event pulse.
- Read: RdData/RdValid are registered. With RdClr, the selected counter is loaded with 1 if its event fires in the same cycle, else 0, so no event is lost.

## Timing
- Reset state: every output 0, FSM HUNT, shift registers 8'hFF, ones-runs 0, bit counters 0, all counters 0.
- Rst overrides everything in the same edge, including a read in flight (RdValid stays 0).
- Detection latency: pulses and levels assert in the cycle after the Clk edge that samples the completing bit. The counter increment is visible to a read issued in that same pulse cycle.
- RdEn at edge n gives RdData/RdValid valid after edge n+1. The value is the pre-increment value from edge n.
- RxEn=0: the channel holds all state and emits no pulses.
- Channels are fully independent; simultaneous events on different channels are all counted.
- Bit-counter saturation forces FrameErr at the closing flag.

## Structure
- Package hdlc_mon_pkg holds:
  - the FSM state enum;
  - the RdSel class enum;
  - the constants FLAG_PAT=8'h7E and ABORT_PAT=8'h7F;
  - the stuff-run length 5.
- Sub-module hdlc_line_monitor_ch: one channel's shift register, run counter, bit counter, FSM and four counters. The top instantiates NUM_CH copies and muxes the read port.

## Test plan
- Reset, then 20 strobed ones on ch0:
  - IdleDetect[0] rises on the 15th one;
  - AbortDetect[0] pulses never (no leading 0);
  - FrameOk[0] and FrameErr[0] stay 0.
- Frame on ch1 (flag, 2 data bytes 8'hFF 8'h00 with stuffing, 2 FCS bytes, flag):
  - FlagDetect pulses twice;
  - FrameOk[1] pulses once, the cycle after the final flag bit;
  - reading RdCh=1 RdSel=0 returns 1.
- Flag, 13 data bits, flag on ch2: FrameErr[2] pulses and the FrameErr count reads 1.
- Flag, 3 bytes, then 0 followed by 7 ones on ch3:
  - AbortDetect[3] pulses;
  - InFrame[3] falls the same cycle;
  - no FrameOk or FrameErr;
  - Abort count reads 1.
- Flag, 129 bytes, flag: FrameErr pulses (oversize). Repeat with 128 bytes: FrameOk pulses.
- FrameOk pulse coincides with RdEn+RdClr on that counter (value 4):
  - RdData = 4;
  - a subsequent read returns 1.
